// File: rtl/baud_pkg.sv
// rtl/baud_pkg.sv - shared defaults, width helper and divisor type for the baud tick generator
package baud_pkg;

  localparam int INT_W_DEF  = 16;
  localparam int FRAC_W_DEF = 4;
  localparam int OVS_DEF    = 16;

  // Bits needed to index OVS oversample ticks (OVS is a power of two)
  function automatic int baud_log2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  typedef struct packed {
    logic [INT_W_DEF-1:0]  div_int;
    logic [FRAC_W_DEF-1:0] div_frac;
  } baud_div_t;

endpackage

// File: rtl/baud_frac_acc.sv
// rtl/baud_frac_acc.sv - fractional phase accumulator producing the period-stretch carry
module baud_frac_acc
  import baud_pkg::*;
#(
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              period_end,
  input  logic [FRAC_W-1:0] div_frac_act,
  output logic              c
);

  logic [FRAC_W-1:0] acc;
  logic [FRAC_W:0]   sum;

  assign sum = {1'b0, acc} + {1'b0, div_frac_act};
  assign c   = sum[FRAC_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (period_end) begin
      acc <= sum[FRAC_W-1:0];
    end
  end

endmodule

// File: rtl/baud_tick_gen.sv
// rtl/baud_tick_gen.sv - fractional baud tick generator with double-buffered divisor
// BAUD_FRAC_EN builds the fractional accumulator; without it div_frac is ignored.
module baud_tick_gen
  import baud_pkg::*;
#(
  parameter int INT_W  = INT_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int OVS    = OVS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              restart,
  input  logic              load,
  input  logic [INT_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              os_tick,
  output logic              mid_tick,
  output logic              bit_tick,
  output logic              cfg_pending
);

  localparam int OVS_W = baud_log2(OVS);
  localparam logic [OVS_W-1:0] MID_IDX  = OVS_W'(OVS / 2 - 1);
  localparam logic [OVS_W-1:0] LAST_IDX = OVS_W'(OVS - 1);

  logic [INT_W-1:0] cnt;
  logic [INT_W-1:0] last;
  logic [INT_W-1:0] base_m1;
  logic [INT_W-1:0] sh_int;
  logic [INT_W-1:0] act_int;
  logic [OVS_W-1:0] os_idx;
  logic             en_q;
  logic             pending;
  logic             running;
  logic             period_end;
  logic             apply;
  logic             clear;
  logic             c;

  // en_q holds the counter at zero on the first enabled edge so the first tick lands L cycles after enable
  assign clear      = restart || !enable;
  assign running    = enable && !restart && en_q;
  assign base_m1    = (act_int == '0) ? '0 : act_int - INT_W'(1);
  assign last       = base_m1 + {{(INT_W-1){1'b0}}, c};
  assign period_end = running && (cnt == last);
  assign apply      = pending && (period_end || !enable);

  assign os_tick     = period_end;
  assign mid_tick    = period_end && (os_idx == MID_IDX);
  assign bit_tick    = period_end && (os_idx == LAST_IDX);
  assign cfg_pending = pending;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      os_idx <= '0;
      en_q   <= 1'b0;
    end else begin
      en_q <= enable;
      if (clear) begin
        cnt    <= '0;
        os_idx <= '0;
      end else if (en_q) begin
        if (period_end) begin
          cnt    <= '0;
          os_idx <= os_idx + OVS_W'(1);
        end else begin
          cnt <= cnt + INT_W'(1);
        end
      end
    end
  end

  // A load coinciding with apply refills the shadow and keeps it pending for the next boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_int  <= '0;
      act_int <= '0;
      pending <= 1'b0;
    end else begin
      if (apply) act_int <= sh_int;
      if (load) begin
        sh_int  <= div_int;
        pending <= 1'b1;
      end else if (apply) begin
        pending <= 1'b0;
      end
    end
  end

`ifdef BAUD_FRAC_EN
  logic [FRAC_W-1:0] sh_frac;
  logic [FRAC_W-1:0] act_frac;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_frac  <= '0;
      act_frac <= '0;
    end else begin
      if (apply) act_frac <= sh_frac;
      if (load) sh_frac <= div_frac;
    end
  end

  baud_frac_acc #(
    .FRAC_W(FRAC_W)
  ) u_frac_acc (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .period_end  (period_end),
    .div_frac_act(act_frac),
    .c           (c)
  );
`else
  logic unused_frac;
  assign unused_frac = ^div_frac;
  assign c = 1'b0;
`endif

endmodule

// File: tb/tb_baud_tick_gen.sv
// tb/tb_baud_tick_gen.sv - directed and random checks of baud_tick_gen against a period-length model
module tb_baud_tick_gen;

  localparam int INT_W  = 16;
  localparam int FRAC_W = 4;
  localparam int OVS    = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic              restart;
  logic              load;
  logic [INT_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              os_tick;
  logic              mid_tick;
  logic              bit_tick;
  logic              cfg_pending;

  always #5 clk = ~clk;

  baud_tick_gen #(
    .INT_W (INT_W),
    .FRAC_W(FRAC_W),
    .OVS   (OVS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .restart    (restart),
    .load       (load),
    .div_int    (div_int),
    .div_frac   (div_frac),
    .os_tick    (os_tick),
    .mid_tick   (mid_tick),
    .bit_tick   (bit_tick),
    .cfg_pending(cfg_pending)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Reference model: remaining cycles of the current period, tick index, fractional remainder
  int m_ai, m_af, m_si, m_sf, m_left, m_idx, m_acc;
  bit m_pend, m_enp;

  int tick_q[$];
  int mid_q[$];
  int bit_q[$];

  int e0, t0, rcyc, guard, span_exp;

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -100000;
  endfunction

  function automatic int period_len();
    int l;
    l = (m_ai == 0) ? 1 : m_ai;
`ifdef BAUD_FRAC_EN
    if (m_acc + m_af >= (1 << FRAC_W)) l++;
`endif
    return l;
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ai = 0; m_af = 0; m_si = 0; m_sf = 0;
    m_left = 0; m_idx = 0; m_acc = 0;
    m_pend = 1'b0; m_enp = 1'b0;
  endtask

  task automatic model_update(input bit e_tick);
    bit apply;
    apply = m_pend && (e_tick || !enable);
    if (restart || !enable) begin
      m_idx = 0; m_acc = 0; m_left = 0;
    end else if (m_enp) begin
      if (e_tick) begin
        m_idx = (m_idx + 1) % OVS;
`ifdef BAUD_FRAC_EN
        m_acc = (m_acc + m_af) % (1 << FRAC_W);
`endif
        m_left = 0;
      end else begin
        m_left--;
      end
    end
    if (apply) begin
      m_ai = m_si;
      m_af = m_sf;
    end
    if (load) begin
      m_si = int'(div_int);
`ifdef BAUD_FRAC_EN
      m_sf = int'(div_frac);
`else
      m_sf = 0;
`endif
      m_pend = 1'b1;
    end else if (apply) begin
      m_pend = 1'b0;
    end
    m_enp = enable;
  endtask

  task automatic cycle();
    bit e_tick;
    @(negedge clk);
    if (rst) model_reset();
    if (m_left == 0) m_left = period_len();
    e_tick = enable && !restart && m_enp && !rst && (m_left == 1);
    chk("os_tick", os_tick, e_tick);
    chk("mid_tick", mid_tick, e_tick && (m_idx == OVS / 2 - 1));
    chk("bit_tick", bit_tick, e_tick && (m_idx == OVS - 1));
    chk("cfg_pending", cfg_pending, m_pend);
    if (os_tick === 1'b1) tick_q.push_back(cyc);
    if (mid_tick === 1'b1) mid_q.push_back(cyc);
    if (bit_tick === 1'b1) bit_q.push_back(cyc);
    @(posedge clk);
    if (!rst) model_update(e_tick);
    cyc++;
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_load(input int di, input int df);
    load     = 1'b1;
    div_int  = INT_W'(di);
    div_frac = FRAC_W'(df);
    cycle();
    load = 1'b0;
  endtask

  task automatic clear_q();
    tick_q.delete();
    mid_q.delete();
    bit_q.delete();
  endtask

  initial begin
    model_reset();
    rst = 1'b1; enable = 1'b0; restart = 1'b0; load = 1'b0;
    div_int = '0; div_frac = '0;
    #1;
    run(2);
    rst = 1'b0;
    cycle();

    // Integer divisor 10
    do_load(10, 0);
    cycle();
    clear_q();
    enable = 1'b1;
    e0 = cyc;
    run(330);
    chk_int("first_tick_latency", qget(tick_q, 0) - e0, 10);
    chk_int("os_period", qget(tick_q, 1) - qget(tick_q, 0), 10);
    chk_int("mid_on_8th", qget(mid_q, 0), qget(tick_q, 7));
    chk_int("first_bit", qget(bit_q, 0) - e0, 160);
    chk_int("bit_period", qget(bit_q, 1) - qget(bit_q, 0), 160);

    // Fractional divisor 10 + 8/16
    enable = 1'b0;
    do_load(10, 8);
    cycle();
    clear_q();
    enable = 1'b1;
    run(200);
`ifdef BAUD_FRAC_EN
    span_exp = 168;
`else
    span_exp = 160;
`endif
    chk_int("span16", qget(tick_q, 16) - qget(tick_q, 0), span_exp);

    // Load mid-period at cnt=3
    enable = 1'b0;
    do_load(10, 0);
    cycle();
    clear_q();
    enable = 1'b1;
    guard = 0;
    while (tick_q.size() < 1 && guard < 40) begin cycle(); guard++; end
    chk_int("wait_first_tick", tick_q.size(), 1);
    t0 = qget(tick_q, 0);
    run(3);
    do_load(5, 0);
    chk("pend_after_load", cfg_pending, 1'b1);
    run(30);
    chk_int("old_period_kept", qget(tick_q, 1) - t0, 10);
    chk_int("new_period_a", qget(tick_q, 2) - qget(tick_q, 1), 5);
    chk_int("new_period_b", qget(tick_q, 3) - qget(tick_q, 2), 5);

    // Restart at os_idx=9, cnt=4
    enable = 1'b0;
    do_load(10, 0);
    cycle();
    clear_q();
    enable = 1'b1;
    guard = 0;
    while (tick_q.size() < 9 && guard < 200) begin cycle(); guard++; end
    chk_int("wait_nine_ticks", tick_q.size(), 9);
    run(4);
    restart = 1'b1;
    rcyc = cyc;
    clear_q();
    cycle();
    restart = 1'b0;
    run(100);
    chk_int("restart_latency", qget(tick_q, 0) - rcyc, 10);
    chk_int("restart_mid", qget(mid_q, 0), qget(tick_q, 7));

    // Enable drop, then reset with a pending load
    run(3);
    enable = 1'b0;
    cycle();
    enable = 1'b1;
    run(7);
    do_load(7, 0);
    run(2);
    rst = 1'b1;
    cycle();
    chk("rst_pending", cfg_pending, 1'b0);
    cycle();
    rst = 1'b0;
    enable = 1'b0;
    cycle();
    clear_q();
    enable = 1'b1;
    run(40);
    chk_int("post_reset_continuous", tick_q.size(), 39);
    chk_int("post_reset_bit", qget(bit_q, 1) - qget(bit_q, 0), 16);

    // div_int boundaries 1 and 0
    for (int d = 1; d >= 0; d--) begin
      enable = 1'b0;
      do_load(d, 0);
      cycle();
      clear_q();
      enable = 1'b1;
      run(40);
      chk_int("div_boundary_ticks", tick_q.size(), 39);
      chk_int("div_boundary_bit", qget(bit_q, 1) - qget(bit_q, 0), 16);
    end

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      enable   = ($urandom_range(0, 99) < 97);
      restart  = ($urandom_range(0, 99) < 2);
      load     = ($urandom_range(0, 99) < 4);
      div_int  = INT_W'($urandom_range(0, 12));
      div_frac = FRAC_W'($urandom);
      rst      = ($urandom_range(0, 999) < 3);
      cycle();
    end
    rst = 1'b0; restart = 1'b0; load = 1'b0;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
